// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : glyph codes, FSM state type and segment decoder shared by
//               the multi-digit seven-segment display driver.
// Rev 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t GLYPH_BLANK = 5'd16;
  localparam glyph_t GLYPH_DASH  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Active-low a..g, with out7[6] = a and out7[0] = g.
  function automatic logic [6:0] seg_pattern(input glyph_t g);
    logic [6:0] s;
    case (g)
      5'd0:       s = 7'h01;
      5'd1:       s = 7'h4F;
      5'd2:       s = 7'h12;
      5'd3:       s = 7'h06;
      5'd4:       s = 7'h4C;
      5'd5:       s = 7'h24;
      5'd6:       s = 7'h20;
      5'd7:       s = 7'h0F;
      5'd8:       s = 7'h00;
      5'd9:       s = 7'h04;
      5'd10:      s = 7'h08;
      5'd11:      s = 7'h60;
      5'd12:      s = 7'h31;
      5'd13:      s = 7'h42;
      5'd14:      s = 7'h30;
      5'd15:      s = 7'h38;
      GLYPH_DASH: s = 7'h7E;
      default:    s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_seq.sv
// ============================================================================
// bcd_dabble_seq : sequential double-dabble binary-to-BCD converter, one bit
//                  per cycle, with sticky overflow when DIGITS is too few.
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_dabble_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      number,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_sh;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_adj;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_ovf;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Asserted during the final step so the caller can move on at the same edge.
  assign done     = r_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_ovf <= 1'b0;
    end else if (start) begin
      r_sh  <= number;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
      r_ovf <= 1'b0;
    end else if (r_run) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_sh[WIDTH-1]};
      r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
      r_ovf <= r_ovf | w_adj[BCD_W-1];
      r_cnt <= r_cnt + CNT_W'(1);
      if (done) r_run <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_digit_display.sv
// ============================================================================
// multi_digit_display : converts Number to decimal or hex glyphs, applies
//                       blanking/DP/overflow and scans DIGITS common-anode digits.
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_digit_display
  import display_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int WIDTH    = 32,
  parameter int SCAN_DIV = 131072
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [WIDTH-1:0]  Number,
  input  logic              Load,
  input  logic              HexMode,
  input  logic              BlankLZ,
  input  logic [DIGITS-1:0] DpMask,
  output logic              Busy,
  output logic [6:0]        out7,
  output logic              dp,
  output logic [DIGITS-1:0] en_out
);

  localparam int NIB_W = 4 * DIGITS;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            r_state;
  logic              r_hex;
  logic              r_blz;
  logic [DIGITS-1:0] r_mask;
  logic [NIB_W-1:0]  r_raw;
  logic              r_hex_ovf;
  glyph_t            r_glyph [DIGITS];
  logic [DIGITS-1:0] r_dp_on;
  logic [PRE_W-1:0]  r_pre;
  logic [IDX_W-1:0]  r_idx;

  logic [NIB_W-1:0]  w_hex_val;
  logic              w_hex_ovf;
  logic [NIB_W-1:0]  w_bcd;
  logic              w_dec_ovf;
  logic              w_done;
  logic              w_start;
  logic [NIB_W-1:0]  w_src;
  logic              w_ovf;
  logic              w_lead;
  glyph_t            w_glyph [DIGITS];
  logic [DIGITS-1:0] w_dpn;

  generate
    if (WIDTH > NIB_W) begin : g_hex_wide
      assign w_hex_val = Number[NIB_W-1:0];
      assign w_hex_ovf = |Number[WIDTH-1:NIB_W];
    end else begin : g_hex_narrow
      assign w_hex_val = NIB_W'(Number);
      assign w_hex_ovf = 1'b0;
    end
  endgenerate

  assign w_start = (r_state == ST_IDLE) && Load && !HexMode;
  assign Busy    = (r_state != ST_IDLE);

  bcd_dabble_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dabble (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .start    (w_start),
    .number   (Number),
    .done     (w_done),
    .bcd      (w_bcd),
    .overflow (w_dec_ovf)
  );

  // Walk from the top digit down; blanking stops at the first nonzero digit.
  always_comb begin
    w_src  = r_hex ? r_raw : w_bcd;
    w_ovf  = r_hex ? r_hex_ovf : w_dec_ovf;
    w_lead = r_blz && !w_ovf;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_dpn[i] = r_mask[i] & ~w_ovf;
      if (w_ovf) begin
        w_glyph[i] = GLYPH_DASH;
      end else if (w_lead && (i != 0) && (w_src[4*i +: 4] == 4'd0)) begin
        w_glyph[i] = GLYPH_BLANK;
      end else begin
        w_glyph[i] = {1'b0, w_src[4*i +: 4]};
        w_lead     = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state   <= ST_IDLE;
      r_hex     <= 1'b0;
      r_blz     <= 1'b0;
      r_mask    <= '0;
      r_raw     <= '0;
      r_hex_ovf <= 1'b0;
      r_dp_on   <= '0;
      for (int i = 0; i < DIGITS; i++) r_glyph[i] <= GLYPH_BLANK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Load) begin
            r_hex     <= HexMode;
            r_blz     <= BlankLZ;
            r_mask    <= DpMask;
            r_raw     <= w_hex_val;
            r_hex_ovf <= w_hex_ovf;
            r_state   <= HexMode ? ST_LATCH : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_done) r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          for (int i = 0; i < DIGITS; i++) r_glyph[i] <= w_glyph[i];
          r_dp_on <= w_dpn;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_pre  <= '0;
      r_idx  <= '0;
      en_out <= '1;
      out7   <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      en_out <= ~(DIGITS'(1) << r_idx);
      out7   <= seg_pattern(r_glyph[r_idx]);
      dp     <= ~r_dp_on[r_idx];
    end
  end

endmodule

`default_nettype wire
